itlb_micro_cache: RTL and testbench

- Small fully-associative micro-TLB between instruction fetch and the fetch lookup port of the main TLB (va0 / pa0 / exp_bus0 / c_com0).
- Hits and unmapped kseg0/kseg1 addresses return a registered translation one cycle after acceptance.
- Misses drive one lookup into the main TLB's combinational fetch port. Valid results are filled and answered; refill/invalid results are answered but not cached.
- Contents are invalidated on any TLB write or ASID change.

---
 rtl/itlb_micro_cache.sv | 230 +++++++++++++++++++++++
 tb/tb_itlb_micro_cache.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/itlb_micro_cache.sv
// itlb_micro_cache: fully-associative micro-TLB between instruction fetch and
// the main TLB fetch port. Unmapped segments and hits answer one cycle after
// acceptance; misses spend one LOOKUP cycle on the main TLB port and answer
// one cycle later. Valid main-TLB results are filled, exceptions are not.

// One micro-TLB slot: stored translation plus a match against the lookup VPN.
module itlb_micro_cache_entry (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        we,
  input  logic [19:0] wr_vpn,
  input  logic [19:0] wr_pfn,
  input  logic [2:0]  wr_c,
  input  logic [19:0] lk_vpn,
  output logic        hit,
  output logic        vld,
  output logic [19:0] pfn,
  output logic [2:0]  c
);
  logic [19:0] vpn_q;

  // Flush and fill never coincide: a fill is only issued in a non-flush cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      vpn_q <= '0;
      pfn   <= '0;
      c     <= '0;
    end else if (flush) begin
      vld   <= 1'b0;
    end else if (we) begin
      vld   <= 1'b1;
      vpn_q <= wr_vpn;
      pfn   <= wr_pfn;
      c     <= wr_c;
    end
  end

  assign hit = vld && (vpn_q == lk_vpn);
endmodule

module itlb_micro_cache #(
  parameter int ENTRIES  = 4,
  parameter int IDX_BITS = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [31:0] req_va,
  output logic        req_ready,
  input  logic [7:0]  asid_i,
  input  logic [2:0]  k0_i,
  input  logic        tlb_we,
  output logic [31:0] tlb_va,
  input  logic [31:0] tlb_pa,
  input  logic [1:0]  tlb_exp,
  input  logic [2:0]  tlb_c,
  output logic        resp_valid,
  output logic [31:0] resp_pa,
  output logic [2:0]  resp_c,
  output logic        resp_refill,
  output logic        resp_invalid
);
  typedef enum logic {IDLE, LOOKUP} state_t;

  typedef struct packed {
    logic [31:0] pa;
    logic [2:0]  c;
    logic        refill;
    logic        invalid;
  } resp_t;

  state_t state_q, state_d;
  resp_t  resp_q, resp_d;
  logic   resp_fire, miss_go;

  logic [7:0] asid_q;
  logic       flush_now;
  logic       req_fire;

  logic [ENTRIES-1:0]        ent_hit, ent_vld, ent_we;
  logic [ENTRIES-1:0][19:0]  ent_pfn;
  logic [ENTRIES-1:0][2:0]   ent_c;

  logic          hit_any;
  logic [19:0]   hit_pfn;
  logic [2:0]    hit_c;
  logic [IDX_BITS-1:0] rr_q, fill_idx;
  logic          fill_rr, fill_en;

  assign flush_now = tlb_we || (asid_i != asid_q);
  assign req_ready = (state_q == IDLE) && !flush_now;
  assign req_fire  = req_valid && req_ready;
  assign fill_en   = (state_q == LOOKUP) && !flush_now && (tlb_exp == 2'b01);

  // Previous ASID, tracked every cycle so any change flushes exactly once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) asid_q <= '0;
    else        asid_q <= asid_i;
  end

  generate
    for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
      itlb_micro_cache_entry u_ent (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush_now),
        .we     (ent_we[g]),
        .wr_vpn (tlb_va[31:12]),
        .wr_pfn (tlb_pa[31:12]),
        .wr_c   (tlb_c),
        .lk_vpn (req_va[31:12]),
        .hit    (ent_hit[g]),
        .vld    (ent_vld[g]),
        .pfn    (ent_pfn[g]),
        .c      (ent_c[g])
      );
    end
  endgenerate

  // Hit select: at most one entry matches, so an OR-mux is sufficient.
  always_comb begin
    hit_any = 1'b0;
    hit_pfn = '0;
    hit_c   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (ent_hit[i]) begin
        hit_any = 1'b1;
        hit_pfn = hit_pfn | ent_pfn[i];
        hit_c   = hit_c | ent_c[i];
      end
    end
  end

  // Victim choice: lowest-index free slot, else the round-robin pointer.
  always_comb begin
    fill_idx = rr_q;
    fill_rr  = 1'b1;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        fill_idx = IDX_BITS'(i);
        fill_rr  = 1'b0;
      end
    end
  end

  // Per-entry write strobes decoded from the victim index.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      ent_we[i] = fill_en && (fill_idx == IDX_BITS'(i));
  end

  // Round-robin pointer only advances when it actually picked the victim.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= '0;
    else if (fill_en && fill_rr)
      rr_q <= (rr_q == IDX_BITS'(ENTRIES - 1)) ? '0 : rr_q + 1'b1;
  end

  // FSM next state and response payload.
  always_comb begin
    state_d   = state_q;
    resp_d    = '0;
    resp_fire = 1'b0;
    miss_go   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_fire) begin
          if (req_va[31:29] == 3'b100) begin
            resp_fire = 1'b1;
            resp_d.pa = {3'b000, req_va[28:0]};
            resp_d.c  = k0_i;
          end else if (req_va[31:29] == 3'b101) begin
            resp_fire = 1'b1;
            resp_d.pa = {3'b000, req_va[28:0]};
            resp_d.c  = 3'd2;
          end else if (hit_any) begin
            resp_fire = 1'b1;
            resp_d.pa = {hit_pfn, req_va[11:0]};
            resp_d.c  = hit_c;
          end else begin
            miss_go = 1'b1;
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        // A flush this cycle means the main TLB changes on this edge; retry.
        if (!flush_now) begin
          resp_fire      = 1'b1;
          resp_d.pa      = tlb_pa;
          resp_d.c       = tlb_c;
          resp_d.refill  = tlb_exp[1];
          resp_d.invalid = !tlb_exp[1] && !tlb_exp[0];
          state_d        = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Latched miss address, held on the main TLB port through LOOKUP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       tlb_va <= '0;
    else if (miss_go) tlb_va <= req_va;
  end

  // Response registers: single-cycle valid pulse, payload held until next.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_q     <= '{pa: '0, c: 3'd3, refill: 1'b0, invalid: 1'b0};
    end else begin
      resp_valid <= resp_fire;
      if (resp_fire) resp_q <= resp_d;
    end
  end

  assign resp_pa      = resp_q.pa;
  assign resp_c       = resp_q.c;
  assign resp_refill  = resp_q.refill;
  assign resp_invalid = resp_q.invalid;
endmodule

// File: tb/tb_itlb_micro_cache.sv
// Randomized + directed bench for itlb_micro_cache against a slot-array model
// of the micro-TLB and a pure-function main TLB.
module tb_itlb_micro_cache;
  localparam int ENTRIES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [31:0] req_va;
  logic        req_ready;
  logic [7:0]  asid_i;
  logic [2:0]  k0_i;
  logic        tlb_we;
  logic [31:0] tlb_va;
  logic [31:0] tlb_pa;
  logic [1:0]  tlb_exp;
  logic [2:0]  tlb_c;
  logic        resp_valid;
  logic [31:0] resp_pa;
  logic [2:0]  resp_c;
  logic        resp_refill;
  logic        resp_invalid;

  logic [7:0]  gen;
  int checks, errors;

  bit          m_vld [ENTRIES];
  logic [19:0] m_vpn [ENTRIES];
  logic [19:0] m_pfn [ENTRIES];
  logic [2:0]  m_c   [ENTRIES];
  int          m_rr;

  always #5 clk = ~clk;

  itlb_micro_cache #(.ENTRIES(ENTRIES), .IDX_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_va(req_va),
    .req_ready(req_ready), .asid_i(asid_i), .k0_i(k0_i), .tlb_we(tlb_we),
    .tlb_va(tlb_va), .tlb_pa(tlb_pa), .tlb_exp(tlb_exp), .tlb_c(tlb_c),
    .resp_valid(resp_valid), .resp_pa(resp_pa), .resp_c(resp_c),
    .resp_refill(resp_refill), .resp_invalid(resp_invalid)
  );

  // Main TLB stand-in: {exp, c, pa}; gen bumps on every TLB write.
  function automatic logic [36:0] mtlb(input logic [31:0] va, input logic [7:0] asid,
                                       input logic [7:0] g);
    logic [19:0] vpn, pfn;
    logic [1:0]  exp;
    logic [2:0]  c;
    vpn = va[31:12];
    if (vpn[19:8] == 12'h005)      exp = 2'b10;
    else if (vpn[19:8] == 12'h006) exp = 2'b00;
    else                           exp = 2'b01;
    if (vpn == 20'h00400) begin
      pfn = 20'h01234 ^ {asid, g, 4'h0};
      c   = 3'd3 ^ g[2:0];
    end else begin
      pfn = vpn ^ 20'hA5A5A ^ {asid, g, 4'h0};
      c   = vpn[2:0] ^ g[2:0] ^ 3'd1;
    end
    return {exp, c, pfn, va[11:0]};
  endfunction

  assign {tlb_exp, tlb_c, tlb_pa} = mtlb(tlb_va, asid_i, gen);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic m_flush();
    for (int i = 0; i < ENTRIES; i++) m_vld[i] = 1'b0;
  endtask

  task automatic m_fill(input logic [19:0] vpn, input logic [19:0] pfn, input logic [2:0] c);
    int idx;
    idx = -1;
    for (int i = 0; i < ENTRIES; i++) if (!m_vld[i] && idx < 0) idx = i;
    if (idx < 0) begin
      idx  = m_rr;
      m_rr = (m_rr + 1) % ENTRIES;
    end
    m_vld[idx] = 1'b1; m_vpn[idx] = vpn; m_pfn[idx] = pfn; m_c[idx] = c;
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_rv"},  resp_valid, 0);
    chk({p, "_pa"},  resp_pa, 0);
    chk({p, "_c"},   resp_c, 3);
    chk({p, "_rf"},  resp_refill, 0);
    chk({p, "_inv"}, resp_invalid, 0);
    chk({p, "_tva"}, tlb_va, 0);
  endtask

  // One request end to end; inj pulses tlb_we during the LOOKUP cycle.
  task automatic do_req(input logic [31:0] va, input bit inj, output int lat);
    int kind, hidx, n, elat;
    logic [31:0] epa;
    logic [2:0]  ec;
    logic        erf, einv;
    logic [36:0] r;
    kind = 2; hidx = 0; r = '0;
    if (va[31:29] == 3'b100 || va[31:29] == 3'b101) kind = 0;
    else for (int i = 0; i < ENTRIES; i++)
      if (m_vld[i] && m_vpn[i] == va[31:12]) begin kind = 1; hidx = i; end
    req_va = va; req_valid = 1'b1; #1;
    n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 0, 1);
      req_valid = 1'b0; lat = 0;
      return;
    end
    ec = va[29] ? 3'd2 : k0_i;
    step(); req_valid = 1'b0; lat = 1;
    while (!resp_valid && lat < 10) begin
      if (lat == 1 && inj && kind == 2) begin tlb_we = 1'b1; gen++; end
      step(); tlb_we = 1'b0; lat++;
    end
    if (inj && kind == 2) m_flush();
    erf = 1'b0; einv = 1'b0;
    case (kind)
      0: begin epa = {3'b000, va[28:0]}; elat = 1; end
      1: begin epa = {m_pfn[hidx], va[11:0]}; ec = m_c[hidx]; elat = 1; end
      default: begin
        r = mtlb(va, asid_i, gen);
        epa = r[31:0]; ec = r[34:32];
        erf = r[36]; einv = !r[36] && !r[35];
        elat = (inj ? 3 : 2);
      end
    endcase
    chk("lat", lat, elat);
    chk("pa", resp_pa, epa);
    chk("c", resp_c, ec);
    chk("refill", resp_refill, erf);
    chk("invalid", resp_invalid, einv);
    if (kind == 2 && r[36:35] == 2'b01) m_fill(va[31:12], r[31:12], r[34:32]);
    step();
    chk("pulse", resp_valid, 0);
  endtask

  task automatic pulse_we();
    tlb_we = 1'b1; gen++; #1;
    chk("we_ready", req_ready, 0);
    step(); tlb_we = 1'b0;
    m_flush();
  endtask

  task automatic set_asid(input logic [7:0] a);
    asid_i = a; #1;
    chk("asid_ready0", req_ready, 0);
    step();
    chk("asid_ready1", req_ready, 1);
    m_flush();
  endtask

  initial begin
    int lat;
    logic [31:0] tv, va;
    checks = 0; errors = 0; gen = '0; m_rr = 0;
    m_flush();
    rst_n = 1'b0; req_valid = 1'b0; req_va = '0; asid_i = '0; k0_i = 3'd3; tlb_we = 1'b0;
    #12;
    chk_rst("rst");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("ready_idle", req_ready, 1);

    // Unmapped segments.
    tv = tlb_va;
    do_req(32'h8000_1234, 0, lat);
    chk("k0_pa", resp_pa, 32'h0000_1234);
    chk("k0_c", resp_c, 3);
    do_req(32'hA000_0010, 0, lat);
    chk("k1_c", resp_c, 2);
    chk("tva_hold", tlb_va, tv);

    // Fill and hit on the same page.
    do_req(32'h0040_0010, 0, lat);
    chk("fill_lat", lat, 2);
    chk("fill_pa", resp_pa, 32'h0123_4010);
    do_req(32'h0040_0FFC, 0, lat);
    chk("hit_lat", lat, 1);
    chk("hit_pa", resp_pa, 32'h0123_4FFC);

    // Exceptions are answered but never cached.
    do_req(32'h0050_0000, 0, lat);
    chk("rf_flag", resp_refill, 1);
    do_req(32'h0050_0000, 0, lat);
    chk("rf_again_lat", lat, 2);
    do_req(32'h0060_0000, 0, lat);
    chk("inv_flag", resp_invalid, 1);

    // Five pages into four slots: fifth evicts slot 0.
    pulse_we();
    for (int i = 0; i < 5; i++) do_req(32'h0010_0000 + i * 32'h1000, 0, lat);
    do_req(32'h0010_1000, 0, lat);
    chk("evict_keep_lat", lat, 1);
    do_req(32'h0010_0000, 0, lat);
    chk("evict_gone_lat", lat, 2);

    // TLB write during LOOKUP retries and flushes.
    do_req(32'h0020_0000, 1, lat);
    chk("we_lookup_lat", lat, 3);
    do_req(32'h0010_2000, 0, lat);
    chk("post_we_lat", lat, 2);

    // ASID change flushes.
    set_asid(8'h5A);
    do_req(32'h0010_2000, 0, lat);
    chk("post_asid_lat", lat, 2);

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      int sel;
      sel = $urandom_range(0, 15);
      k0_i = 3'($urandom);
      case (sel)
        0: va = {3'b100, 29'($urandom)};
        1: va = {3'b101, 29'($urandom)};
        2: va = {12'h005, 8'($urandom), 12'($urandom)};
        3: va = {12'h006, 8'($urandom), 12'($urandom)};
        4: va = {3'b110, 29'($urandom)};
        default: va = {20'h00400 + 20'($urandom_range(0, 5)), 12'($urandom)};
      endcase
      do_req(va, ($urandom_range(0, 9) == 0), lat);
      if ($urandom_range(0, 19) == 0) pulse_we();
      if ($urandom_range(0, 19) == 0) set_asid(asid_i + 8'($urandom_range(1, 255)));
    end

    // Reset while in LOOKUP.
    pulse_we();
    req_va = 32'h0030_0000; req_valid = 1'b1; #1;
    chk("rl_ready", req_ready, 1);
    step(); req_valid = 1'b0;
    chk("rl_busy", req_ready, 0);
    chk("rl_tva", tlb_va, 32'h0030_0000);
    rst_n = 1'b0; #1;
    chk_rst("rl");
    m_flush(); m_rr = 0;
    step(); step();
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rl_noresp", resp_valid, 0);
    end
    chk("rl_idle", req_ready, 1);
    do_req(32'h0030_0000, 0, lat);
    chk("rl_after_lat", lat, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
    $fatal(1, "timeout");
  end
endmodule
